// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - CHIP-8 DXYN sprite draw and 00E0 clear engine for the 64x32 framebuffer
module sprite_blitter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [3:0]  n,
    input  logic [11:0] i,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  fb_addr,
    input  logic [7:0]  fb_rdata,
    output logic        fb_we,
    output logic [7:0]  fb_wdata
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, RD_L, WR_L, RD_R, WR_R, DONE
    } state_t;

    state_t      state, next;
    logic [5:0]  x0;
    logic [4:0]  y0;
    logic [11:0] base;
    logic [3:0]  rows;
    logic [3:0]  row;
    logic [7:0]  sprite;
    logic [7:0]  counter;

    logic [15:0] window;
    logic [7:0]  l_mask, r_mask;
    logic [4:0]  yr;
    logic [2:0]  col_r;
    logic [3:0]  row_next;
    logic        last_row;
    logic        aligned;
    logic        unused_bits;

    // Only the low 6/5 bits of the coordinates matter: the screen wraps.
    assign unused_bits = ^{x[7:6], y[7:5]};

    assign window   = {sprite, 8'h00} >> x0[2:0];
    assign l_mask   = window[15:8];
    assign r_mask   = window[7:0];
    assign yr       = y0 + {1'b0, row};
    assign col_r    = x0[5:3] + 3'd1;
    assign row_next = row + 4'd1;
    assign last_row = (row_next == rows);
    assign aligned  = (x0[2:0] == 3'd0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        mem_rd   = 1'b0;
        mem_addr = 12'h000;
        fb_we    = 1'b0;
        fb_addr  = 8'h00;
        fb_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (clear) begin
                    next = CLEAR;
                end else if (start) begin
                    next = (n == 4'd0) ? DONE : FETCH;
                end
            end
            CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = counter;
                if (counter == 8'hFF) begin
                    next = DONE;
                end
            end
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = base + {8'h00, row};
                next     = RD_L;
            end
            RD_L: begin
                fb_addr = {yr, x0[5:3]};
                next    = WR_L;
            end
            WR_L: begin
                fb_we    = 1'b1;
                fb_addr  = {yr, x0[5:3]};
                fb_wdata = fb_rdata ^ l_mask;
                if (!aligned) begin
                    next = RD_R;
                end else begin
                    next = last_row ? DONE : FETCH;
                end
            end
            RD_R: begin
                fb_addr = {yr, col_r};
                next    = WR_R;
            end
            WR_R: begin
                fb_we    = 1'b1;
                fb_addr  = {yr, col_r};
                fb_wdata = fb_rdata ^ r_mask;
                next     = last_row ? DONE : FETCH;
            end
            DONE: begin
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0        <= 6'd0;
            y0        <= 5'd0;
            base      <= 12'h000;
            rows      <= 4'd0;
            row       <= 4'd0;
            sprite    <= 8'h00;
            counter   <= 8'h00;
            collision <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        collision <= 1'b0;
                        counter   <= 8'h00;
                    end else if (start) begin
                        x0        <= x[5:0];
                        y0        <= y[4:0];
                        base      <= i;
                        rows      <= n;
                        row       <= 4'd0;
                        collision <= 1'b0;
                    end
                end
                CLEAR: counter <= counter + 8'd1;
                RD_L:  sprite  <= mem_rdata;
                WR_L: begin
                    if ((fb_rdata & l_mask) != 8'h00) begin
                        collision <= 1'b1;
                    end
                    if (aligned) begin
                        row <= row_next;
                    end
                end
                WR_R: begin
                    if ((fb_rdata & r_mask) != 8'h00) begin
                        collision <= 1'b1;
                    end
                    row <= row_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter with memory and framebuffer models
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst_n, start, clear;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] i;
    logic        busy, done, collision, mem_rd, fb_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata, fb_addr, fb_rdata, fb_wdata;

    logic [7:0]  fb_mem [256];
    logic [7:0]  mm [4096];
    int          cyc = 0;
    int          t0 = 0;
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    logic [11:0] rd_q[$];
    logic [11:0] exp_rd[$];
    typedef struct {int dcyc; logic coll;} exp_t;
    exp_t        exp_q[$];

    sprite_blitter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .x(x), .y(y), .n(n), .i(i),
        .busy(busy), .done(done), .collision(collision),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_we(fb_we), .fb_wdata(fb_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fb_we) fb_mem[fb_addr] <= fb_wdata;
        fb_rdata  <= fb_mem[fb_addr];
        mem_rdata <= mm[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n && mem_rd) rd_q.push_back(mem_addr);
        if (rst_n && fb_we) wr_cnt = wr_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic zero_fb();
        for (int k = 0; k < 256; k++) fb_mem[k] <= 8'h00;
        #1;
    endtask

    task automatic drive_req(input logic st, input logic cl, input logic [7:0] xv,
                             input logic [7:0] yv, input logic [3:0] nv, input logic [11:0] iv);
        @(posedge clk); #1;
        start = st; clear = cl; x = xv; y = yv; n = nv; i = iv;
        t0 = cyc;
        rd_q.delete();
        wr_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int dc, output logic bok);
        dc = -1;
        bok = 1'b1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (!busy) bok = 1'b0;
            if (done) begin
                dc = cyc - t0;
                break;
            end
        end
    endtask

    function automatic logic reads_ok();
        logic ok;
        logic [11:0] a;
        ok = (rd_q.size() == exp_rd.size());
        while (exp_rd.size() > 0) begin
            a = exp_rd.pop_front();
            if (rd_q.size() == 0) ok = 1'b0;
            else if (rd_q.pop_front() !== a) ok = 1'b0;
        end
        rd_q.delete();
        return ok;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, collision, mem_rd, fb_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {busy, done, collision, mem_rd, fb_we});
        end
    endtask

    task automatic test_clear();
        int dc, bad;
        logic bok;
        exp_t e;
        for (int k = 0; k < 256; k++) fb_mem[k] <= 8'hAA;
        exp_q.push_back('{257, 1'b0});
        drive_req(1'b0, 1'b1, 8'd0, 8'd0, 4'd0, 12'h000);
        wait_done(400, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc) begin failures++; $display("FAIL clear_done got=%0d exp=%0d", dc, e.dcyc); end
        checks++;
        if (collision !== e.coll) begin failures++; $display("FAIL clear_coll got=%b exp=%b", collision, e.coll); end
        checks++;
        if (!bok) begin failures++; $display("FAIL clear_busy got=gap exp=continuous"); end
        checks++;
        if (rd_q.size() != 0 || wr_cnt != 256) begin
            failures++; $display("FAIL clear_traffic got=rd%0d/wr%0d exp=rd0/wr256", rd_q.size(), wr_cnt);
        end
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (fb_mem[k] !== 8'h00) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clear_bytes got=%0d_nonzero exp=0", bad); end
    endtask

    task automatic test_aligned();
        int dc;
        logic bok;
        exp_t e;
        logic [7:0] ef0, ef1;
        mm[12'h300] = 8'hF0; mm[12'h301] = 8'h90;
        zero_fb();
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{7, logic'(r == 1)});
            exp_rd.push_back(12'h300); exp_rd.push_back(12'h301);
            ef0 = (r == 0) ? 8'hF0 : 8'h00;
            ef1 = (r == 0) ? 8'h90 : 8'h00;
            drive_req(1'b1, 1'b0, 8'd8, 8'd2, 4'd2, 12'h300);
            wait_done(40, dc, bok);
            e = exp_q.pop_front();
            checks++;
            if (dc !== e.dcyc) begin failures++; $display("FAIL aligned%0d_done got=%0d exp=%0d", r, dc, e.dcyc); end
            checks++;
            if (collision !== e.coll) begin failures++; $display("FAIL aligned%0d_coll got=%b exp=%b", r, collision, e.coll); end
            checks++;
            if (!bok || !reads_ok()) begin failures++; $display("FAIL aligned%0d_reads got=bad exp=300,301", r); end
            @(posedge clk); #1;
            checks++;
            if (fb_mem[17] !== ef0 || fb_mem[25] !== ef1) begin
                failures++; $display("FAIL aligned%0d_fb got=%h,%h exp=%h,%h", r, fb_mem[17], fb_mem[25], ef0, ef1);
            end
        end
    endtask

    task automatic test_n_zero();
        int dc;
        logic bok;
        exp_t e;
        exp_q.push_back('{1, 1'b0});
        drive_req(1'b1, 1'b0, 8'd8, 8'd2, 4'd0, 12'h300);
        wait_done(10, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc) begin failures++; $display("FAIL nzero_done got=%0d exp=%0d", dc, e.dcyc); end
        checks++;
        if (collision !== e.coll) begin failures++; $display("FAIL nzero_coll got=%b exp=%b", collision, e.coll); end
        checks++;
        if (rd_q.size() != 0 || wr_cnt != 0) begin
            failures++; $display("FAIL nzero_traffic got=rd%0d/wr%0d exp=0/0", rd_q.size(), wr_cnt);
        end
    endtask

    task automatic test_unaligned();
        int dc;
        logic bok;
        exp_t e;
        logic [7:0] xs [2];
        xs[0] = 8'd5; xs[1] = 8'd69;
        mm[12'h300] = 8'hFF;
        for (int r = 0; r < 2; r++) begin
            zero_fb();
            exp_q.push_back('{6, 1'b0});
            drive_req(1'b1, 1'b0, xs[r], 8'd0, 4'd1, 12'h300);
            wait_done(40, dc, bok);
            e = exp_q.pop_front();
            checks++;
            if (dc !== e.dcyc) begin failures++; $display("FAIL unal_x%0d_done got=%0d exp=%0d", xs[r], dc, e.dcyc); end
            @(posedge clk); #1;
            checks++;
            if (fb_mem[0] !== 8'h07 || fb_mem[1] !== 8'hF8 || collision !== e.coll) begin
                failures++;
                $display("FAIL unal_x%0d_fb got=%h,%h,%b exp=07,f8,0", xs[r], fb_mem[0], fb_mem[1], collision);
            end
        end
    endtask

    task automatic test_wrap();
        int dc;
        logic bok;
        exp_t e;
        mm[12'h300] = 8'hFF; mm[12'h301] = 8'h81;
        zero_fb();
        exp_q.push_back('{11, 1'b0});
        drive_req(1'b1, 1'b0, 8'd62, 8'd31, 4'd2, 12'h300);
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc || collision !== e.coll) begin
            failures++; $display("FAIL wrap_done got=%0d/%b exp=%0d/%b", dc, collision, e.dcyc, e.coll);
        end
        @(posedge clk); #1;
        checks++;
        if (fb_mem[255] !== 8'h03 || fb_mem[248] !== 8'hFC || fb_mem[7] !== 8'h02 || fb_mem[0] !== 8'h04) begin
            failures++;
            $display("FAIL wrap_fb got=%h,%h,%h,%h exp=03,fc,02,04", fb_mem[255], fb_mem[248], fb_mem[7], fb_mem[0]);
        end
    endtask

    task automatic test_addr_wrap();
        int dc;
        logic bok;
        exp_t e;
        mm[12'hFFF] = 8'h11; mm[12'h000] = 8'h22;
        zero_fb();
        fb_mem[80] <= 8'h11;
        #1;
        exp_q.push_back('{7, 1'b1});
        exp_rd.push_back(12'hFFF); exp_rd.push_back(12'h000);
        drive_req(1'b1, 1'b0, 8'd0, 8'd10, 4'd2, 12'hFFF);
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc || collision !== e.coll) begin
            failures++; $display("FAIL awrap_done got=%0d/%b exp=%0d/%b", dc, collision, e.dcyc, e.coll);
        end
        checks++;
        if (!reads_ok()) begin failures++; $display("FAIL awrap_reads got=bad exp=fff,000"); end
        @(posedge clk); #1;
        checks++;
        if (fb_mem[80] !== 8'h00 || fb_mem[88] !== 8'h22) begin
            failures++; $display("FAIL awrap_fb got=%h,%h exp=00,22", fb_mem[80], fb_mem[88]);
        end
    endtask

    task automatic test_busy_ignore();
        int dc, extra;
        logic bok;
        exp_t e;
        mm[12'h300] = 8'hF0;
        zero_fb();
        exp_q.push_back('{4, 1'b0});
        drive_req(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h300);
        start = 1'b1; clear = 1'b1; x = 8'd16; n = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc) begin failures++; $display("FAIL ignore_done got=%0d exp=%0d", dc, e.dcyc); end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy) extra++;
        end
        checks++;
        if (extra != 0 || wr_cnt != 1 || fb_mem[0] !== 8'hF0 || fb_mem[2] !== 8'h00) begin
            failures++;
            $display("FAIL ignore_effect got=busy%0d/wr%0d/%h/%h exp=0/1/f0/00", extra, wr_cnt, fb_mem[0], fb_mem[2]);
        end
    endtask

    task automatic test_start_clear();
        int dc, bad;
        logic bok;
        exp_t e;
        exp_q.push_back('{257, 1'b0});
        drive_req(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, 12'h300);
        wait_done(400, dc, bok);
        e = exp_q.pop_front();
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 256; k++) if (fb_mem[k] !== 8'h00) bad++;
        checks++;
        if (dc !== e.dcyc || rd_q.size() != 0 || bad != 0) begin
            failures++; $display("FAIL both_clear got=%0d/rd%0d/nz%0d exp=%0d/0/0", dc, rd_q.size(), bad, e.dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        logic bok;
        exp_t e;
        mm[12'h300] = 8'hF0; mm[12'h310] = 8'hC0;
        zero_fb();
        exp_q.push_back('{4, 1'b0});
        exp_q.push_back('{6, 1'b0});
        drive_req(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h300);
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", dc, e.dcyc); end
        drive_req(1'b1, 1'b0, 8'd3, 8'd1, 4'd1, 12'h310);
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        checks++;
        if (dc !== e.dcyc || !bok) begin failures++; $display("FAIL b2b_second got=%0d exp=%0d", dc, e.dcyc); end
        @(posedge clk); #1;
        checks++;
        if (fb_mem[0] !== 8'hF0 || fb_mem[8] !== 8'h18 || fb_mem[9] !== 8'h00) begin
            failures++; $display("FAIL b2b_fb got=%h,%h,%h exp=f0,18,00", fb_mem[0], fb_mem[8], fb_mem[9]);
        end
    endtask

    task automatic test_reset_mid();
        int dc, seen;
        logic bok;
        exp_t e;
        mm[12'h300] = 8'hF0;
        zero_fb();
        drive_req(1'b1, 1'b0, 8'd0, 8'd0, 4'd15, 12'h300);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, collision, mem_rd, fb_we} !== 5'b0) begin
            failures++; $display("FAIL rstmid_outputs got=%b exp=00000", {busy, done, collision, mem_rd, fb_we});
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", seen); end
        zero_fb();
        exp_q.push_back('{4, 1'b0});
        drive_req(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h300);
        wait_done(40, dc, bok);
        e = exp_q.pop_front();
        @(posedge clk); #1;
        checks++;
        if (dc !== e.dcyc || fb_mem[0] !== 8'hF0) begin
            failures++; $display("FAIL rstmid_fresh got=%0d/%h exp=%0d/f0", dc, fb_mem[0], e.dcyc);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        x = 8'd0; y = 8'd0; n = 4'd0; i = 12'h000;
        for (int k = 0; k < 4096; k++) mm[k] = 8'h00;
        for (int k = 0; k < 256; k++) fb_mem[k] <= 8'h00;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_clear();
        test_aligned();
        test_n_zero();
        test_unaligned();
        test_wrap();
        test_addr_wrap();
        test_busy_ignore();
        test_start_clear();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
